// File: rtl/dpram_be.sv
// dpram_be: true dual-port RAM with per-lane byte enables.
//
// Both ports share one clock and have equal capability. Each port can read,
// write, or read and write in the same cycle. Same-port read-during-write
// behaviour is selected by RDW_MODE (0 read-first, 1 write-first,
// 2 no-change). A cross-port read of an address being written in the same
// cycle always returns the pre-write word. OUT_REG=1 adds one output pipeline
// stage to both ports. Overlapping same-address dual writes are resolved per
// lane in favour of the PRIORITY port (0 = A, 1 = B) and flagged on
// `collision` one cycle later.
//
// Ports (A shown, B identical):
//   clK              clock, all logic on the rising edge
//   rst              synchronous active-high reset (outputs only, not memory)
//   a_port_EN        port enable; low means no read and no write
//   a_port_WR        write request, qualified by a_port_EN
//   a_port_BE        lane write enables, bit i covers data [i*LANE +: LANE]
//   a_port_ADDR      word address
//   a_port_data_IN   write data
//   a_port_data_OUT  read data, holds its value between reads
//   a_port_VALID     one-cycle pulse when a_port_data_OUT is a fresh result
//   collision        pulse: previous cycle had an overlapping dual write
module dpram_be #(
    parameter int unsigned DATA     = 16,
    parameter int unsigned ADDR     = 5,
    parameter int unsigned LANE     = 8,
    parameter int unsigned RDW_MODE = 0,
    parameter int unsigned OUT_REG  = 0,
    parameter int unsigned PRIORITY = 0
) (
    input  logic                 clK,
    input  logic                 rst,

    input  logic                 a_port_EN,
    input  logic                 a_port_WR,
    input  logic [DATA/LANE-1:0] a_port_BE,
    input  logic [ADDR-1:0]      a_port_ADDR,
    input  logic [DATA-1:0]      a_port_data_IN,
    output logic [DATA-1:0]      a_port_data_OUT,
    output logic                 a_port_VALID,

    input  logic                 b_port_EN,
    input  logic                 b_port_WR,
    input  logic [DATA/LANE-1:0] b_port_BE,
    input  logic [ADDR-1:0]      b_port_ADDR,
    input  logic [DATA-1:0]      b_port_data_IN,
    output logic [DATA-1:0]      b_port_data_OUT,
    output logic                 b_port_VALID,

    output logic                 collision
);

    localparam int unsigned NL    = DATA / LANE;
    localparam int unsigned DEPTH = 1 << ADDR;

    // Expand a lane-enable vector into a per-bit mask.
    function automatic logic [DATA-1:0] lane_bits(input logic [NL-1:0] be);
        logic [DATA-1:0] bits;
        bits = '0;
        for (int i = 0; i < int'(NL); i++) begin
            bits[i*LANE +: LANE] = {LANE{be[i]}};
        end
        return bits;
    endfunction

    // Index 0 is port A, index 1 is port B.
    logic [1:0]                 en;
    logic [1:0]                 wr;
    logic [1:0]                 we;
    logic [1:0]                 rd_req;
    logic [1:0][NL-1:0]         be;
    logic [1:0][NL-1:0]         wmask;
    logic [1:0][ADDR-1:0]       addr;
    logic [1:0][DATA-1:0]       wdata;
    logic [1:0][DATA-1:0]       old_word;
    logic [1:0][DATA-1:0]       rd_word;
    logic                       dual_wr;

    logic [DATA-1:0]            mem_q [DEPTH];

    logic [1:0][DATA-1:0]       s1_data_q, s1_data_d;
    logic [1:0]                 s1_vld_q, s1_vld_d;
    logic                       collision_q, collision_d;

    logic [1:0][DATA-1:0]       out_data;
    logic [1:0]                 out_vld;

    always_comb begin
        en    = {b_port_EN, a_port_EN};
        wr    = {b_port_WR, a_port_WR};
        be    = {b_port_BE, a_port_BE};
        addr  = {b_port_ADDR, a_port_ADDR};
        wdata = {b_port_data_IN, a_port_data_IN};
    end

    // Write qualification and lane arbitration.
    always_comb begin
        we = en & wr & {2{~rst}};
        dual_wr = we[0] & we[1] & (addr[0] == addr[1]);
        wmask[0] = we[0] ? be[0] : '0;
        wmask[1] = we[1] ? be[1] : '0;
        // On a same-address dual write the losing port drops only the
        // overlapping lanes; its non-overlapping lanes still land.
        if (dual_wr) begin
            if (PRIORITY == 0) begin
                wmask[1] = be[1] & ~be[0];
            end else begin
                wmask[0] = be[0] & ~be[1];
            end
        end
        collision_d = dual_wr & ((be[0] & be[1]) != '0);
    end

    // Read path: old_word is always the pre-write contents, which also gives
    // read-first semantics for cross-port reads in every mode.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            old_word[p] = mem_q[addr[p]];
            if (wr[p] && RDW_MODE == 1) begin
                // Port's own merged view; ignores the other port's data.
                rd_word[p] = (wdata[p] & lane_bits(be[p])) |
                             (old_word[p] & ~lane_bits(be[p]));
            end else begin
                rd_word[p] = old_word[p];
            end
            rd_req[p]    = en[p] & ~rst & ~(wr[p] && RDW_MODE == 2);
            s1_vld_d[p]  = rd_req[p];
            s1_data_d[p] = rd_req[p] ? rd_word[p] : s1_data_q[p];
        end
    end

    // Storage: no reset, contents survive rst.
    always_ff @(posedge clK) begin
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < int'(NL); i++) begin
                if (wmask[p][i]) begin
                    mem_q[addr[p]][i*LANE +: LANE] <= wdata[p][i*LANE +: LANE];
                end
            end
        end
    end

    always_ff @(posedge clK) begin
        if (rst) begin
            s1_data_q   <= '0;
            s1_vld_q    <= '0;
            collision_q <= 1'b0;
        end else begin
            s1_data_q   <= s1_data_d;
            s1_vld_q    <= s1_vld_d;
            collision_q <= collision_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [1:0][DATA-1:0] s2_data_q, s2_data_d;
        logic [1:0]           s2_vld_q, s2_vld_d;

        // Second stage only reloads on a fresh result so the output holds
        // across idle cycles.
        always_comb begin
            for (int p = 0; p < 2; p++) begin
                s2_data_d[p] = s1_vld_q[p] ? s1_data_q[p] : s2_data_q[p];
            end
            s2_vld_d = s1_vld_q;
        end

        always_ff @(posedge clK) begin
            if (rst) begin
                s2_data_q <= '0;
                s2_vld_q  <= '0;
            end else begin
                s2_data_q <= s2_data_d;
                s2_vld_q  <= s2_vld_d;
            end
        end

        assign out_data = s2_data_q;
        assign out_vld  = s2_vld_q;
    end else begin : g_no_out_reg
        assign out_data = s1_data_q;
        assign out_vld  = s1_vld_q;
    end

    assign a_port_data_OUT = out_data[0];
    assign a_port_VALID    = out_vld[0];
    assign b_port_data_OUT = out_data[1];
    assign b_port_VALID    = out_vld[1];
    assign collision       = collision_q;

endmodule

// File: tb/tb_dpram_be.sv
// Directed bench for dpram_be. Three instances share one stimulus stream:
//   d0: read-first,  no output reg, A priority
//   d1: write-first, output reg,    B priority
//   d2: no-change,   no output reg, A priority
module tb_dpram_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        ea, wa, eb, wb;
    logic [1:0]  bea, beb;
    logic [4:0]  aa, ab;
    logic [15:0] dia, dib;

    logic [15:0] da [3];
    logic [15:0] db [3];
    logic        va [3];
    logic        vb [3];
    logic        col [3];

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_mem [32];

    always #5 clk = ~clk;

    dpram_be #(.RDW_MODE(0), .OUT_REG(0), .PRIORITY(0)) d0 (
        .clK(clk), .rst(rst),
        .a_port_EN(ea), .a_port_WR(wa), .a_port_BE(bea), .a_port_ADDR(aa),
        .a_port_data_IN(dia), .a_port_data_OUT(da[0]), .a_port_VALID(va[0]),
        .b_port_EN(eb), .b_port_WR(wb), .b_port_BE(beb), .b_port_ADDR(ab),
        .b_port_data_IN(dib), .b_port_data_OUT(db[0]), .b_port_VALID(vb[0]),
        .collision(col[0])
    );

    dpram_be #(.RDW_MODE(1), .OUT_REG(1), .PRIORITY(1)) d1 (
        .clK(clk), .rst(rst),
        .a_port_EN(ea), .a_port_WR(wa), .a_port_BE(bea), .a_port_ADDR(aa),
        .a_port_data_IN(dia), .a_port_data_OUT(da[1]), .a_port_VALID(va[1]),
        .b_port_EN(eb), .b_port_WR(wb), .b_port_BE(beb), .b_port_ADDR(ab),
        .b_port_data_IN(dib), .b_port_data_OUT(db[1]), .b_port_VALID(vb[1]),
        .collision(col[1])
    );

    dpram_be #(.RDW_MODE(2), .OUT_REG(0), .PRIORITY(0)) d2 (
        .clK(clk), .rst(rst),
        .a_port_EN(ea), .a_port_WR(wa), .a_port_BE(bea), .a_port_ADDR(aa),
        .a_port_data_IN(dia), .a_port_data_OUT(da[2]), .a_port_VALID(va[2]),
        .b_port_EN(eb), .b_port_WR(wb), .b_port_BE(beb), .b_port_ADDR(ab),
        .b_port_data_IN(dib), .b_port_data_OUT(db[2]), .b_port_VALID(vb[2]),
        .collision(col[2])
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_a(input logic e, input logic w, input logic [1:0] be,
                         input logic [4:0] ad, input logic [15:0] d);
        ea = e; wa = w; bea = be; aa = ad; dia = d;
    endtask

    task automatic set_b(input logic e, input logic w, input logic [1:0] be,
                         input logic [4:0] ad, input logic [15:0] d);
        eb = e; wb = w; beb = be; ab = ad; dib = d;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
        set_b(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();

        // Reset state on every instance.
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_da%0d", k), da[k], 16'h0);
            chk($sformatf("rst_va%0d", k), {15'b0, va[k]}, 16'h0);
            chk($sformatf("rst_db%0d", k), db[k], 16'h0);
            chk($sformatf("rst_vb%0d", k), {15'b0, vb[k]}, 16'h0);
            chk($sformatf("rst_col%0d", k), {15'b0, col[k]}, 16'h0);
        end
        rst = 1'b0;

        // Fill addr*0x0101.
        for (int i = 0; i < 32; i++) begin
            exp_mem[i] = 16'(i * 16'h0101);
            set_a(1'b1, 1'b1, 2'b11, 5'(i), exp_mem[i]);
            tick();
        end

        // Reset during a read of addr 3 suppresses it.
        set_a(1'b1, 1'b0, 2'b00, 5'd3, 16'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rstrd_da%0d", k), da[k], 16'h0);
            chk($sformatf("rstrd_va%0d", k), {15'b0, va[k]}, 16'h0);
        end
        tick();
        chk("rst_drop_va1", {15'b0, va[1]}, 16'h0);
        chk("rst_drop_da1", da[1], 16'h0);

        // Memory retained across reset.
        set_a(1'b1, 1'b0, 2'b00, 5'd3, 16'h0);
        tick();
        idle();
        chk("ret_da0", da[0], 16'h0303);
        chk("ret_va0", {15'b0, va[0]}, 16'h1);
        chk("ret_da2", da[2], 16'h0303);
        chk("ret_va1_early", {15'b0, va[1]}, 16'h0);
        tick();
        chk("ret_da1", da[1], 16'h0303);
        chk("ret_va1", {15'b0, va[1]}, 16'h1);
        chk("hold_da0", da[0], 16'h0303);
        chk("hold_va0", {15'b0, va[0]}, 16'h0);

        // Byte enables via port B.
        set_b(1'b1, 1'b1, 2'b11, 5'd5, 16'hAAAA);
        tick();
        set_b(1'b1, 1'b1, 2'b01, 5'd5, 16'h1234);
        tick();
        exp_mem[5] = 16'hAA34;
        set_b(1'b1, 1'b0, 2'b00, 5'd5, 16'h0);
        tick();
        idle();
        chk("be_db0", db[0], 16'hAA34);
        chk("be_db2", db[2], 16'hAA34);
        tick();
        chk("be_db1", db[1], 16'hAA34);
        chk("be_vb1", {15'b0, vb[1]}, 16'h1);

        // Read-during-write modes at addr 7.
        set_a(1'b1, 1'b1, 2'b11, 5'd7, 16'h1111);
        tick();
        set_a(1'b1, 1'b1, 2'b11, 5'd7, 16'h2222);
        tick();
        exp_mem[7] = 16'h2222;
        idle();
        chk("rdw0_da", da[0], 16'h1111);
        chk("rdw0_va", {15'b0, va[0]}, 16'h1);
        chk("rdw2_da", da[2], 16'h0303);
        chk("rdw2_va", {15'b0, va[2]}, 16'h0);
        tick();
        chk("rdw1_da", da[1], 16'h2222);
        chk("rdw1_va", {15'b0, va[1]}, 16'h1);
        set_a(1'b1, 1'b0, 2'b00, 5'd7, 16'h0);
        tick();
        idle();
        chk("rdw_rd_da0", da[0], 16'h2222);
        chk("rdw_rd_da2", da[2], 16'h2222);
        chk("rdw_rd_va2", {15'b0, va[2]}, 16'h1);
        tick();
        chk("rdw_rd_da1", da[1], 16'h2222);

        // Overlapping dual write at addr 9 (old 0x0909).
        set_a(1'b1, 1'b1, 2'b11, 5'd9, 16'h00FF);
        set_b(1'b1, 1'b1, 2'b01, 5'd9, 16'hFF00);
        tick();
        exp_mem[9] = 16'h00FF;
        idle();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("col_hi%0d", k), {15'b0, col[k]}, 16'h1);
        end
        chk("col_rf_da0", da[0], 16'h0909);
        chk("col_rf_db0", db[0], 16'h0909);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("col_lo%0d", k), {15'b0, col[k]}, 16'h0);
        end
        chk("col_wf_da1", da[1], 16'h00FF);
        chk("col_wf_db1", db[1], 16'h0900);
        set_a(1'b1, 1'b0, 2'b00, 5'd9, 16'h0);
        tick();
        idle();
        chk("col_word_d0", da[0], 16'h00FF);
        chk("col_word_d2", da[2], 16'h00FF);
        tick();
        chk("col_word_d1", da[1], 16'h0000);

        // Disjoint-lane dual write at addr 10.
        set_a(1'b1, 1'b1, 2'b10, 5'd10, 16'hAB00);
        set_b(1'b1, 1'b1, 2'b01, 5'd10, 16'h00CD);
        tick();
        exp_mem[10] = 16'hABCD;
        set_a(1'b1, 1'b0, 2'b00, 5'd10, 16'h0);
        set_b(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("disj_col%0d", k), {15'b0, col[k]}, 16'h0);
        end
        tick();
        idle();
        chk("disj_d0", da[0], 16'hABCD);
        chk("disj_d2", da[2], 16'hABCD);
        tick();
        chk("disj_d1", da[1], 16'hABCD);

        // Cross-port read of a word being written.
        set_a(1'b1, 1'b1, 2'b11, 5'd12, 16'h5555);
        tick();
        set_a(1'b1, 1'b1, 2'b11, 5'd12, 16'h6666);
        set_b(1'b1, 1'b0, 2'b00, 5'd12, 16'h0);
        tick();
        exp_mem[12] = 16'h6666;
        idle();
        chk("xp_db0", db[0], 16'h5555);
        chk("xp_vb0", {15'b0, vb[0]}, 16'h1);
        chk("xp_db2", db[2], 16'h5555);
        tick();
        chk("xp_db1", db[1], 16'h5555);
        set_a(1'b1, 1'b0, 2'b00, 5'd12, 16'h0);
        tick();
        idle();
        chk("xp_after_d0", da[0], 16'h6666);

        // 32 back-to-back reads on B: continuous VALID.
        for (int i = 0; i < 32; i++) begin
            set_b(1'b1, 1'b0, 2'b00, 5'(i), 16'h0);
            tick();
            chk($sformatf("tp_vb0_%0d", i), {15'b0, vb[0]}, 16'h1);
            chk($sformatf("tp_db0_%0d", i), db[0], exp_mem[i]);
            if (i > 0) begin
                chk($sformatf("tp_vb1_%0d", i), {15'b0, vb[1]}, 16'h1);
            end
        end
        idle();
        tick();
        chk("tp_end_vb0", {15'b0, vb[0]}, 16'h0);
        chk("tp_end_vb1", {15'b0, vb[1]}, 16'h1);
        chk("tp_end_db1", db[1], exp_mem[31]);
        tick();
        chk("tp_end2_vb1", {15'b0, vb[1]}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dpram_be.md
# dpram_be

Parametrised true dual-port RAM with per-lane byte write enables, a selectable read-during-write mode, an optional output pipeline register, a read-valid strobe and write-collision detection. It is the next-generation storage primitive under the FIFO and buffering blocks. Both ports share one clock and have equal capability. Port priority resolves same-address write conflicts deterministically.

## Interface
- DATA, 16, word width in bits; must be a multiple of LANE
- ADDR, 5, address width; depth = 2**ADDR words
- LANE, 8, bits per write-enable lane; NL = DATA/LANE lanes
- RDW_MODE, 0, same-port read-during-write: 0 read-first, 1 write-first, 2 no-change
- OUT_REG, 0, 1 adds one output pipeline stage to both ports
- PRIORITY, 0, winner on overlapping same-address writes: 0 port A, 1 port B
- clK  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- a_port_EN  in  1  port A enable; low means no read and no write
- a_port_WR  in  1  port A write (qualified by a_port_EN)
- a_port_BE  in  NL  port A lane enables; bit i covers data bits [i*LANE +: LANE]
- a_port_ADDR  in  ADDR  port A address
- a_port_data_IN  in  DATA  port A write data
- a_port_data_OUT  out  DATA  port A read data
- a_port_VALID  out  1  a_port_data_OUT holds a fresh read result this cycle
- b_port_EN, b_port_WR, b_port_BE, b_port_ADDR, b_port_data_IN, b_port_data_OUT, b_port_VALID: identical to port A
- collision  out  1  registered pulse: previous cycle had an overlapping same-address dual write

## Operation
- Memory: 2**ADDR x DATA. Contents are not cleared by reset and are undefined until written.
- Write: EN&WR&!rst writes lanes with BE=1. Lanes with BE=0 keep their old value. WR with BE=0 is a legal no-op write.
- Read: EN=1 issues a read of ADDR. Reads occur with or without WR, subject to RDW_MODE.
- Same-port read-during-write (EN&WR):
  - 0 read-first: output is the pre-write word; VALID=1.
  - 1 write-first: output is the merged word (new lanes where BE=1, old elsewhere); VALID=1.
  - 2 no-change: data_OUT holds; VALID=0.
- Cross-port: a port reading an address the other port writes in the same cycle returns the pre-write word in all modes.
- Dual write, same address, overlapping lanes (BE_A & BE_B != 0):
  - The PRIORITY port's data lands on overlapping lanes.
  - Non-overlapping lanes from both ports are written.
  - collision=1 next cycle.
- Dual write, same address, disjoint lanes: both written; no collision.
- Write-first output on a collided address shows the port's own merged view: its own new lanes, old data elsewhere. It does not reflect the other port's data.
- EN=0: data_OUT holds its last value; VALID=0.

## Timing
- Reset (rst=1 at an edge):
  - Sets data_OUT=0, VALID=0 on both ports, collision=0, and clears the OUT_REG stage.
  - Suppresses writes and reads issued in that cycle.
- Read latency: 1 cycle with OUT_REG=0. A request at edge N gives data/VALID after edge N+1; with OUT_REG=1, after edge N+2.
- VALID is a one-cycle pulse per accepted read. Back-to-back reads give continuous VALID and full throughput on both ports.
- collision appears after edge N+1 for a conflict at edge N, independent of OUT_REG. It is high for exactly one cycle per conflicting cycle.
- With OUT_REG=1, a reset mid-pipeline drops the in-flight read: no VALID after reset deasserts until a new request is issued.
- ADDR wraps naturally; address 2**ADDR-1 has no special handling.

## Test plan
- Reset: fill addr 0..31 with value addr*0x0101, assert rst during a read of addr 3 -> next cycle data_OUT=0, VALID=0. Memory is retained: a later read of addr 3 returns 0x0303.
- Byte enables: write 0xAAAA to addr 5, then WR BE=2'b01 data 0x1234 -> read returns 0xAA34 after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
- RDW modes, addr 7 holding 0x1111, port A writes 0x2222 BE=11 with EN:
  - mode 0 -> data_OUT=0x1111, VALID=1
  - mode 1 -> data_OUT=0x2222, VALID=1
  - mode 2 -> data_OUT unchanged, VALID=0
  - a following read returns 0x2222 in all modes
- Collision: A writes 0x00FF BE=11 and B writes 0xFF00 BE=01, both to addr 9, PRIORITY=0 -> word becomes 0x0000? No: lane0 overlaps and A wins (0xFF), lane1 from A (0x00) -> 0x00FF; collision=1 for one cycle. Same stimulus with PRIORITY=1 -> 0x0000.
- Disjoint lanes: A BE=10 data 0xAB00, B BE=01 data 0x00CD, same addr -> word 0xABCD, collision=0.
- Cross-port plus throughput: B reads addr 12 (old 0x5555) while A writes 0x6666 -> B gets 0x5555. 32 consecutive reads give VALID high for 32 consecutive cycles.
